// File: rtl/bp_pkg.sv
// Shared types and helpers for the bimodal branch predictor.
// 2-bit saturating counter encoding, its reset value and next-state rule.
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_ctr_t;

  localparam bp_ctr_t     BP_CTR_RESET = WNT;
  localparam logic [31:0] BP_CNT_MAX   = 32'hFFFF_FFFF;

  // Saturating step toward the observed outcome
  function automatic bp_ctr_t bp_ctr_next(input bp_ctr_t ctr, input logic taken);
    bp_ctr_t nxt;
    nxt = BP_CTR_RESET;
    case (ctr)
      SNT:     nxt = taken ? WNT : SNT;
      WNT:     nxt = taken ? WT  : SNT;
      WT:      nxt = taken ? ST  : WNT;
      ST:      nxt = taken ? ST  : WT;
      default: nxt = BP_CTR_RESET;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/bp_counter_table.sv
// Counter array with one write port and one read port. The write port carries the
// pending outcome; the read port sees that outcome's next-state before it is written.
module bp_counter_table
  import bp_pkg::*;
#(
  parameter int unsigned IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken,
  input  logic [IDX_W-1:0] rd_idx,
  output bp_ctr_t          rd_ctr_c
);

  localparam int unsigned DEPTH = 2 ** IDX_W;

  bp_ctr_t mem [DEPTH];
  bp_ctr_t wr_next_c;

  // Next-state is formed at write time so back-to-back updates to one index chain
  always_comb begin
    wr_next_c = bp_ctr_next(mem[wr_idx], wr_taken);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[IDX_W'(i)] <= BP_CTR_RESET;
      end
    end else if (wr_en) begin
      mem[wr_idx] <= wr_next_c;
    end
  end

  always_comb begin
    rd_ctr_c = mem[rd_idx];
    if (wr_en && (rd_idx == wr_idx)) begin
      rd_ctr_c = wr_next_c;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch predictor: zero-latency lookup for ID, two-edge update from EX.
// Define BP_GSHARE_EN to XOR a global history register into both indices.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned IDX_W = 6,
  parameter int unsigned PC_W  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            lk_valid,
  input  logic [PC_W-1:0] lk_pc,
  output logic            predict,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic            upd_predicted,
  output logic            mispredict,
  output logic [31:0]     br_count,
  output logic [31:0]     miss_count
);

  logic [IDX_W-1:0] lk_idx_c;
  logic [IDX_W-1:0] upd_idx_c;
  logic             miss_c;
  logic             pend_valid;
  logic [IDX_W-1:0] pend_idx;
  logic             pend_taken;
  bp_ctr_t          rd_ctr_c;
  logic             unused_pc_bits;

  assign unused_pc_bits = ^{lk_pc[PC_W-1:IDX_W+2], lk_pc[1:0],
                            upd_pc[PC_W-1:IDX_W+2], upd_pc[1:0]};

`ifdef BP_GSHARE_EN
  logic [IDX_W-1:0] ghr;

  // Update index uses the history as it stood before this cycle's shift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr <= '0;
    end else if (upd_valid) begin
      ghr <= {ghr[IDX_W-2:0], upd_taken};
    end
  end

  assign lk_idx_c  = lk_pc[IDX_W+1:2] ^ ghr;
  assign upd_idx_c = upd_pc[IDX_W+1:2] ^ ghr;
`else
  assign lk_idx_c  = lk_pc[IDX_W+1:2];
  assign upd_idx_c = upd_pc[IDX_W+1:2];
`endif

  // U1: hold the resolved outcome for one cycle; the table applies it at U2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_idx   <= '0;
      pend_taken <= 1'b0;
    end else begin
      pend_valid <= upd_valid;
      if (upd_valid) begin
        pend_idx   <= upd_idx_c;
        pend_taken <= upd_taken;
      end
    end
  end

  bp_counter_table #(
    .IDX_W (IDX_W)
  ) u_table (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (pend_valid),
    .wr_idx   (pend_idx),
    .wr_taken (pend_taken),
    .rd_idx   (lk_idx_c),
    .rd_ctr_c (rd_ctr_c)
  );

  assign predict = lk_valid ? rd_ctr_c[1] : 1'b0;
  assign miss_c  = upd_valid && (upd_taken != upd_predicted);

  // Statistics saturate instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispredict <= 1'b0;
      br_count   <= '0;
      miss_count <= '0;
    end else begin
      mispredict <= miss_c;
      if (upd_valid && (br_count != BP_CNT_MAX)) begin
        br_count <= br_count + 32'd1;
      end
      if (miss_c && (miss_count != BP_CNT_MAX)) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: an outcome-level table model checked
// every cycle, plus directed vectors with hand-computed expectations.
module tb_branch_predictor;

  localparam int unsigned IDX_W = 6;
  localparam int unsigned PC_W  = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            lk_valid = 1'b0;
  logic [PC_W-1:0] lk_pc = '0;
  logic            predict;
  logic            upd_valid = 1'b0;
  logic [PC_W-1:0] upd_pc = '0;
  logic            upd_taken = 1'b0;
  logic            upd_predicted = 1'b0;
  logic            mispredict;
  logic [31:0]     br_count;
  logic [31:0]     miss_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: every resolved branch is applied at once; a lookup sees all earlier ones
  int m_ctr [64];
  int m_ghr;
  int m_br;
  int m_miss;
  bit m_mis;

  always #5 clk = ~clk;

  branch_predictor #(
    .IDX_W (IDX_W),
    .PC_W  (PC_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .lk_valid      (lk_valid),
    .lk_pc         (lk_pc),
    .predict       (predict),
    .upd_valid     (upd_valid),
    .upd_pc        (upd_pc),
    .upd_taken     (upd_taken),
    .upd_predicted (upd_predicted),
    .mispredict    (mispredict),
    .br_count      (br_count),
    .miss_count    (miss_count)
  );

  function automatic int midx(input logic [31:0] pc);
    int i;
    i = int'((pc >> 2) & 32'h3F);
`ifdef BP_GSHARE_EN
    i = i ^ m_ghr;
`endif
    return i;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Hand-computed vectors assume plain bimodal indexing
  task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
`ifndef BP_GSHARE_EN
    check(name, got, exp);
`endif
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) m_ctr[i] = 1;
      m_ghr  = 0;
      m_br   = 0;
      m_miss = 0;
      m_mis  = 1'b0;
    end else begin
      m_mis = upd_valid && (upd_taken != upd_predicted);
      if (upd_valid) begin
        int i;
        i = midx(upd_pc);
        if (upd_taken) m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
        else           m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
        m_br++;
        if (m_mis) m_miss++;
        m_ghr = ((m_ghr << 1) | int'(upd_taken)) & 63;
      end
    end
  end

  always @(negedge clk) begin
    int exp_pred;
    exp_pred = 0;
    if (lk_valid === 1'b1) exp_pred = (m_ctr[midx(lk_pc)] >= 2) ? 1 : 0;
    check("model_predict", 32'(predict), 32'(exp_pred));
    check("model_mispredict", 32'(mispredict), 32'(m_mis));
    check("model_br_count", br_count, 32'(m_br));
    check("model_miss_count", miss_count, 32'(m_miss));
  end

  // Drive one cycle's inputs just after the edge, then settle before sampling
  task automatic step(input logic lv, input logic [31:0] lpc, input logic uv,
                      input logic [31:0] upc, input logic ut, input logic up);
    @(posedge clk);
    #2;
    lk_valid      = lv;
    lk_pc         = lpc;
    upd_valid     = uv;
    upd_pc        = upc;
    upd_taken     = ut;
    upd_predicted = up;
    #1;
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] pcs [5];
    pcs[0] = 32'h100; pcs[1] = 32'h200; pcs[2] = 32'h104;
    pcs[3] = 32'h1FC; pcs[4] = 32'h300;

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    step(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
    lit("reset_predict", 32'(predict), 32'h0);
    lit("reset_br_count", br_count, 32'h0);
    lit("reset_miss_count", miss_count, 32'h0);
    lit("reset_mispredict", 32'(mispredict), 32'h0);

    step(1'b0, 32'h0, 1'b1, 32'h100, 1'b1, 1'b1);
    step(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
    lit("bypass_predict", 32'(predict), 32'h1);
    step(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
    lit("table_predict", 32'(predict), 32'h1);

    repeat (4) step(1'b0, 32'h0, 1'b1, 32'h100, 1'b1, 1'b1);
    step(1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 1'b0);
    lit("same_cycle_pre_update", 32'(predict), 32'h1);
    step(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
    lit("hysteresis_predict", 32'(predict), 32'h1);
    step(1'b0, 32'h0, 1'b1, 32'h100, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 32'h100, 1'b0, 1'b0);
    step(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
    lit("not_taken_predict", 32'(predict), 32'h0);
    lit("train_br_count", br_count, 32'd8);
    lit("train_miss_count", miss_count, 32'd0);

    step(1'b0, 32'h0, 1'b1, 32'h100, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b1, 32'h100, 1'b1, 1'b1);
    step(1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 1'b0);
    lit("alias_predict", 32'(predict), 32'h1);
    step(1'b1, 32'h104, 1'b0, 32'h0, 1'b0, 1'b0);
    lit("neighbour_predict", 32'(predict), 32'h0);

    // Reset lands while a taken update to 0x104 is pending
    step(1'b0, 32'h0, 1'b1, 32'h104, 1'b1, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    lk_valid = 1'b0; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_predicted = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    step(1'b1, 32'h104, 1'b0, 32'h0, 1'b0, 1'b0);
    lit("pending_discarded", 32'(predict), 32'h0);
    step(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
    lit("table_reset", 32'(predict), 32'h0);
    lit("rst2_br_count", br_count, 32'h0);
    lit("rst2_miss_count", miss_count, 32'h0);
    lit("rst2_mispredict", 32'(mispredict), 32'h0);

    step(1'b0, 32'h0, 1'b1, 32'h10, 1'b1, 1'b0);
    lit("miss_not_yet", 32'(mispredict), 32'h0);
    idle();
    lit("miss_pulse", 32'(mispredict), 32'h1);
    lit("miss_br_count", br_count, 32'd1);
    lit("miss_miss_count", miss_count, 32'd1);
    step(1'b0, 32'h0, 1'b1, 32'h10, 1'b1, 1'b1);
    lit("miss_cleared", 32'(mispredict), 32'h0);
    idle();
    lit("match_mispredict", 32'(mispredict), 32'h0);
    lit("match_br_count", br_count, 32'd2);
    lit("match_miss_count", miss_count, 32'd1);

    @(posedge clk);
    #2;
    lk_valid = 1'b0;
    lk_pc = 'x;
    #1;
    lit("x_pc_guard", 32'(predict), 32'h0);
    lk_pc = '0;

    for (int n = 0; n < 300; n++) begin
      step(1'($urandom_range(0, 1)), pcs[$urandom_range(0, 4)],
           1'($urandom_range(0, 1)), pcs[$urandom_range(0, 4)],
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    idle();
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Bimodal branch history table (BHT) on the resolving side of the branch interface.
- ID consumes `predict` while decoding conditional branches (beq/blt).
- EX resolves each branch and reports the real outcome back here, which trains the table and flags mispredicts.
- It sits beside the ID stage. It feeds ID's prediction input and consumes EX resolution.

Parameters:
- IDX_W, 6, table index width; the table holds 2^IDX_W 2-bit counters.
- PC_W, 32, instruction address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- lk_valid  in  1  ID holds a conditional branch this cycle.
- lk_pc  in  PC_W  PC of the branch in ID.
- predict  out  1  predicted taken (combinational from lk_pc).
- upd_valid  in  1  EX resolved a conditional branch this cycle.
- upd_pc  in  PC_W  PC of the resolved branch.
- upd_taken  in  1  actual outcome.
- upd_predicted  in  1  prediction that was carried with the branch down the pipe.
- mispredict  out  1  registered one-cycle pulse on a wrong prediction.
- br_count  out  32  number of resolved branches.
- miss_count  out  32  number of mispredicts.

Behaviour:
- Reset (async, rst_n=0):
  - every table entry = 2'b01 (weakly not-taken);
  - pending-update register invalid;
  - mispredict=0, br_count=0, miss_count=0.
  - An update pending at reset assertion is discarded.
- Index = pc[IDX_W+1:2]. pc[1:0] is ignored.
- Lookup:
  - predict = entry[idx(lk_pc)][1] when lk_valid=1; predict=0 when lk_valid=0.
  - Zero-cycle latency.
- Update pipeline:
  - Stage U1 (edge after upd_valid=1): capture idx(upd_pc) and upd_taken into the pending register and set pending valid.
  - Stage U2 (next edge): write the counter next-state into the table.
  - The table therefore reflects an update 2 edges after upd_valid.
  - Back-to-back updates are accepted every cycle with no stall.
- Counter next-state, saturating:
  - taken: 00→01→10→11→11;
  - not-taken: 11→10→01→00→00.
- Bypass:
  - If pending valid and the lookup idx equals the pending idx, predict = bit 1 of the pending next-state, not the stale table value.
  - Consecutive updates to the same idx chain correctly: U1 computes its next-state from the bypassed value of any in-flight U2 write to that idx.
- mispredict:
  - Set at the edge after upd_valid=1 with upd_taken≠upd_predicted.
  - Cleared at the following edge unless re-triggered.
- Statistics:
  - br_count increments on every upd_valid.
  - miss_count increments with each mispredict set.
  - Both saturate at 0xFFFF_FFFF and never wrap.
- Simultaneous lookup and update of the same idx in one cycle: the lookup sees the pre-update value. Only the U1→U2 window is bypassed.
- X on lk_pc with lk_valid=0 must not propagate to predict.

Optional Feature:
- Macro: BP_GSHARE_EN.
- Defined:
  - Add an IDX_W-bit global history register ghr, reset to 0.
  - On each upd_valid, ghr = {ghr[IDX_W-2:0], upd_taken}, updated at the U1 edge.
  - Lookup idx = pc[IDX_W+1:2] ^ ghr.
  - Update idx = upd_pc[IDX_W+1:2] ^ ghr, using ghr as it was before the shift in the same cycle.
- Undefined: pure bimodal indexing; no ghr is present.

Decomposition:
- Package bp_pkg holds:
  - typedef bp_ctr_t (2-bit: SNT=00, WNT=01, WT=10, ST=11);
  - constant BP_CTR_RESET=WNT;
  - pure function bp_ctr_next(ctr, taken);
  - constant BP_CNT_MAX=32'hFFFF_FFFF.
- Sub-module bp_counter_table: counter array, async reset, one write port, one read port with pending-write bypass.
- The top level holds the index hashing, U1 register, mispredict and statistics.

Test Plan:
- Reset, then lk_valid=1 with lk_pc=0x100 → predict=0; br_count=0, miss_count=0, mispredict=0.
- One taken update for upd_pc=0x100 → lookup of 0x100 one edge later gives predict=1 via bypass; two edges later gives predict=1 from the table.
- 4 taken updates to 0x100, then 1 not-taken → predict=1. After 2 further not-taken updates → predict=0. Checks saturation at 11 and hysteresis.
- IDX_W=6: taken updates to 0x100 then lookup of 0x200 (same idx 0) → predict=1; lookup of 0x104 → predict=0. Checks aliasing and index slicing.
- upd_valid=1, upd_taken=1, upd_predicted=0 for one cycle → mispredict high exactly one cycle, br_count=1, miss_count=1. A following matching update leaves miss_count=1 and sets br_count=2.
- Assert rst_n low while an update is pending → entry stays 01 (predict=0 after release); counters=0. With BP_GSHARE_EN defined, ghr=0 after release.
